// File: rtl/pi_loop_sequencer.sv
// rtl/pi_loop_sequencer.sv - sequencer that closes a PI control loop around a fixed-latency PI pipeline
//
// Purpose:
//   Takes one ADC sample at a time, presents actual/setpoint/stored integral to
//   the PI pipeline, holds them for PIPE_LATENCY cycles, captures the PI result
//   and the updated integral (clamped for anti-windup), then offers the result
//   to the DAC side.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   enable                   run the loop (checked in IDLE and at end of sample)
//   clear_integral           zero the stored integral
//   setpoint                 signed target, latched with each accepted sample
//   adc_valid/adc_ready/adc_data          ADC sample handshake
//   pipe_setpoint/pipe_actual/pipe_integral_input   held inputs to pipeline
//   pipe_integral_result/pipe_pi_result   pipeline outputs
//   dac_valid/dac_ready/dac_data          DAC result handshake
//   integral_value           stored integral
//   sample_count             completed samples (wrapping)
//   busy                     state is not IDLE
module pi_loop_sequencer #(
  parameter int INPUT_WIDTH  = 18,
  parameter int OUTPUT_WIDTH = 32,
  parameter int PIPE_LATENCY = 5,
  parameter logic signed [OUTPUT_WIDTH-1:0] INTEGRAL_MIN = -32'sh80000,
  parameter logic signed [OUTPUT_WIDTH-1:0] INTEGRAL_MAX = 32'sh7FFFF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    clear_integral,
  input  logic [INPUT_WIDTH-1:0]  setpoint,
  input  logic                    adc_valid,
  input  logic [INPUT_WIDTH-1:0]  adc_data,
  output logic                    adc_ready,
  output logic [INPUT_WIDTH-1:0]  pipe_setpoint,
  output logic [INPUT_WIDTH-1:0]  pipe_actual,
  output logic [OUTPUT_WIDTH-1:0] pipe_integral_input,
  input  logic [OUTPUT_WIDTH-1:0] pipe_integral_result,
  input  logic [OUTPUT_WIDTH-1:0] pipe_pi_result,
  output logic                    dac_valid,
  output logic [OUTPUT_WIDTH-1:0] dac_data,
  input  logic                    dac_ready,
  output logic [OUTPUT_WIDTH-1:0] integral_value,
  output logic [31:0]             sample_count,
  output logic                    busy
);

  // Wide enough to hold PIPE_LATENCY (the counter steps once past the last value).
  localparam int CNT_W = $clog2(PIPE_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PIPE_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SAMPLE,
    S_RUN,
    S_CAPTURE,
    S_OUTPUT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                    w_adc_ready;
  logic                    w_busy;
  logic [CNT_W-1:0]        r_cnt;
  logic [INPUT_WIDTH-1:0]  r_pipe_setpoint;
  logic [INPUT_WIDTH-1:0]  r_pipe_actual;
  logic [OUTPUT_WIDTH-1:0] r_pipe_integral;
  logic                    r_dac_valid;
  logic [OUTPUT_WIDTH-1:0] r_dac_data;
  logic [OUTPUT_WIDTH-1:0] r_integral;
  logic [31:0]             r_sample_count;
  logic signed [OUTPUT_WIDTH-1:0] w_int_result;
  logic signed [OUTPUT_WIDTH-1:0] w_int_clamped;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_adc_ready = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (enable) w_next = S_WAIT_SAMPLE;
      end
      S_WAIT_SAMPLE: begin
        w_adc_ready = 1'b1;
        // A pending sample wins over a dropped enable.
        if (adc_valid)     w_next = S_RUN;
        else if (!enable)  w_next = S_IDLE;
      end
      S_RUN: begin
        if (r_cnt == LAST_CNT) w_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_next = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (dac_ready) w_next = enable ? S_WAIT_SAMPLE : S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Anti-windup: signed clamp of the pipeline's updated integral.
  always_comb begin
    w_int_result  = $signed(pipe_integral_result);
    w_int_clamped = w_int_result;
    if (w_int_result < INTEGRAL_MIN)      w_int_clamped = INTEGRAL_MIN;
    else if (w_int_result > INTEGRAL_MAX) w_int_clamped = INTEGRAL_MAX;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt           <= '0;
      r_pipe_setpoint <= '0;
      r_pipe_actual   <= '0;
      r_pipe_integral <= '0;
      r_dac_valid     <= 1'b0;
      r_dac_data      <= '0;
      r_integral      <= '0;
      r_sample_count  <= '0;
    end else begin
      case (r_state)
        S_WAIT_SAMPLE: begin
          if (adc_valid) begin
            r_pipe_actual   <= adc_data;
            r_pipe_setpoint <= setpoint;
            r_pipe_integral <= r_integral;
            r_cnt           <= '0;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
        end
        S_CAPTURE: begin
          r_dac_data  <= pipe_pi_result;
          r_dac_valid <= 1'b1;
        end
        S_OUTPUT: begin
          if (dac_ready) begin
            r_dac_valid    <= 1'b0;
            r_sample_count <= r_sample_count + 32'd1;
          end
        end
        default: begin
        end
      endcase

      // Clear wins over the capture update; the held pipe_integral_input is untouched.
      if (clear_integral) begin
        r_integral <= '0;
      end else if (r_state == S_CAPTURE) begin
        r_integral <= w_int_clamped;
      end
    end
  end

  assign adc_ready           = w_adc_ready;
  assign busy                = w_busy;
  assign pipe_setpoint       = r_pipe_setpoint;
  assign pipe_actual         = r_pipe_actual;
  assign pipe_integral_input = r_pipe_integral;
  assign dac_valid           = r_dac_valid;
  assign dac_data            = r_dac_data;
  assign integral_value      = r_integral;
  assign sample_count        = r_sample_count;

endmodule
